// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm-time storage, alarm match against the time-of-day
// counter, and the IDLE / RING / SNOOZE sequencing that drives the buzzer.
// All outputs are registered; the next-state logic is purely combinational.
module alarm_ctrl #(
    parameter int SNOOZE_MIN     = 9,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       arm,
    input  logic       set_alarm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       set_pm,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] al_hh,
    output logic [7:0] al_mm,
    output logic       al_pm,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzz,
    output logic [2:0] snooze_left,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [15:0] SNZ_LOAD   = 16'(SNOOZE_MIN * 60);
    localparam logic [7:0]  RING_LIMIT = 8'(RING_TIMEOUT_S);
    localparam logic [2:0]  SNZ_MAX    = 3'(MAX_SNOOZE);

    state_t      state_r;
    state_t      state_n_s;
    logic [7:0]  ring_tmr_r;
    logic [7:0]  ring_tmr_n_s;
    logic [15:0] snz_cnt_r;
    logic [15:0] snz_cnt_n_s;
    logic        beep_r;
    logic        beep_n_s;
    logic [2:0]  snz_left_n_s;
    logic        set_ok_s;
    logic        match_s;

    // A 12-hour clock time is legal when the hour is 1..12 and minute 0..59.
    function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m);
        return (h >= 8'd1) && (h <= 8'd12) && (m <= 8'd59);
    endfunction

    // Validate the requested alarm time and detect the once-per-day alarm match.
    always_comb begin
        set_ok_s = time_ok(set_hh, set_mm);
        match_s  = ena && arm && (hh == al_hh) && (mm == al_mm) &&
                   (ss == 8'd0) && (pm == al_pm);
    end

    // Next-state logic; branch order encodes the arm > set > stop > snooze > tick priority.
    always_comb begin
        state_n_s    = state_r;
        ring_tmr_n_s = ring_tmr_r;
        snz_cnt_n_s  = snz_cnt_r;
        beep_n_s     = beep_r;
        snz_left_n_s = snooze_left;
        if (!arm) begin
            state_n_s    = ST_IDLE;
            ring_tmr_n_s = 8'd0;
            snz_cnt_n_s  = 16'd0;
            beep_n_s     = 1'b0;
            snz_left_n_s = SNZ_MAX;
        end else if (set_alarm) begin
            // A rejected load leaves the sequencer frozen for this cycle.
            if (set_ok_s) begin
                state_n_s    = ST_IDLE;
                ring_tmr_n_s = 8'd0;
                snz_cnt_n_s  = 16'd0;
                beep_n_s     = 1'b0;
                snz_left_n_s = SNZ_MAX;
            end else begin
                state_n_s = state_r;
            end
        end else if (stop && (state_r != ST_IDLE)) begin
            state_n_s    = ST_IDLE;
            ring_tmr_n_s = 8'd0;
            snz_cnt_n_s  = 16'd0;
            beep_n_s     = 1'b0;
            snz_left_n_s = SNZ_MAX;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (match_s) begin
                        state_n_s    = ST_RING;
                        ring_tmr_n_s = 8'd0;
                        beep_n_s     = 1'b1;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RING: begin
                    if (snooze && (snooze_left != 3'd0)) begin
                        state_n_s    = ST_SNOOZE;
                        snz_left_n_s = snooze_left - 3'd1;
                        snz_cnt_n_s  = SNZ_LOAD;
                        ring_tmr_n_s = 8'd0;
                        beep_n_s     = 1'b0;
                    end else if (ena) begin
                        if ((ring_tmr_r + 8'd1) == RING_LIMIT) begin
                            state_n_s    = ST_IDLE;
                            ring_tmr_n_s = 8'd0;
                            beep_n_s     = 1'b0;
                            snz_left_n_s = SNZ_MAX;
                        end else begin
                            ring_tmr_n_s = ring_tmr_r + 8'd1;
                            beep_n_s     = ~beep_r;
                        end
                    end else begin
                        state_n_s = ST_RING;
                    end
                end
                ST_SNOOZE: begin
                    if (ena) begin
                        if (snz_cnt_r <= 16'd1) begin
                            state_n_s    = ST_RING;
                            snz_cnt_n_s  = 16'd0;
                            ring_tmr_n_s = 8'd0;
                            beep_n_s     = 1'b1;
                        end else begin
                            snz_cnt_n_s = snz_cnt_r - 16'd1;
                        end
                    end else begin
                        state_n_s = ST_SNOOZE;
                    end
                end
                default: begin
                    state_n_s    = ST_IDLE;
                    ring_tmr_n_s = 8'd0;
                    snz_cnt_n_s  = 16'd0;
                    beep_n_s     = 1'b0;
                    snz_left_n_s = SNZ_MAX;
                end
            endcase
        end
    end

    // State, counters, alarm registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ring_tmr_r  <= 8'd0;
            snz_cnt_r   <= 16'd0;
            beep_r      <= 1'b0;
            al_hh       <= 8'd7;
            al_mm       <= 8'd0;
            al_pm       <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
            buzz        <= 1'b0;
            snooze_left <= SNZ_MAX;
            load_err    <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            ring_tmr_r  <= ring_tmr_n_s;
            snz_cnt_r   <= snz_cnt_n_s;
            beep_r      <= beep_n_s;
            ringing     <= (state_n_s == ST_RING);
            snoozing    <= (state_n_s == ST_SNOOZE);
            buzz        <= (state_n_s == ST_RING) && beep_n_s;
            snooze_left <= snz_left_n_s;
            load_err    <= set_alarm && !set_ok_s;
            // Alarm registers follow any legal load, armed or not.
            if (set_alarm && set_ok_s) begin
                al_hh <= set_hh;
                al_mm <= set_mm;
                al_pm <= set_pm;
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenarios plus randomized traffic, every output
// compared each cycle against a seconds-based behavioural model.
module tb_alarm_ctrl;

    localparam int SNOOZE_MIN     = 9;
    localparam int RING_TIMEOUT_S = 60;
    localparam int MAX_SNOOZE     = 3;

    localparam int MD_IDLE   = 0;
    localparam int MD_RING   = 1;
    localparam int MD_SNOOZE = 2;

    logic       clk;
    logic       reset;
    logic       ena;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       arm;
    logic       set_alarm;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic       set_pm;
    logic       snooze;
    logic       stop;
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       al_pm;
    logic       ringing;
    logic       snoozing;
    logic       buzz;
    logic [2:0] snooze_left;
    logic       load_err;

    int n_chk;
    int n_err;
    bit chk_en;

    // model: mode, seconds rung, seconds of snooze left, snoozes used
    int         m_mode;
    int         m_ring_s;
    int         m_snz_s;
    int         m_used;
    logic [7:0] m_al_h;
    logic [7:0] m_al_m;
    logic       m_al_p;
    logic       m_err;

    alarm_ctrl #(
        .SNOOZE_MIN    (SNOOZE_MIN),
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .MAX_SNOOZE    (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ena        (ena),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .pm         (pm),
        .arm        (arm),
        .set_alarm  (set_alarm),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_pm     (set_pm),
        .snooze     (snooze),
        .stop       (stop),
        .al_hh      (al_hh),
        .al_mm      (al_mm),
        .al_pm      (al_pm),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .buzz       (buzz),
        .snooze_left(snooze_left),
        .load_err   (load_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_buzz();
        return (m_mode == MD_RING) && ((m_ring_s % 2) == 0);
    endfunction

    // Check DUT and model against a hand-computed literal.
    task automatic lit(input string name, input logic [15:0] dut_v, input logic [15:0] mdl_v,
                       input logic [15:0] exp);
        chk(name, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    task automatic to_idle();
        m_mode   = MD_IDLE;
        m_ring_s = 0;
        m_snz_s  = 0;
        m_used   = 0;
    endtask

    task automatic start_ring();
        m_mode   = MD_RING;
        m_ring_s = 0;
    endtask

    task automatic model_step();
        bit ok;
        ok = (set_hh >= 8'd1) && (set_hh <= 8'd12) && (set_mm <= 8'd59);
        if (!reset) begin
            to_idle();
            m_al_h = 8'd7;
            m_al_m = 8'd0;
            m_al_p = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_err = set_alarm && !ok;
            if (!arm) begin
                to_idle();
            end else if (set_alarm) begin
                if (ok) to_idle();
            end else if (stop && (m_mode != MD_IDLE)) begin
                to_idle();
            end else if (m_mode == MD_IDLE) begin
                if (ena && (hh == m_al_h) && (mm == m_al_m) && (ss == 8'd0) && (pm == m_al_p))
                    start_ring();
            end else if (m_mode == MD_RING) begin
                if (snooze && (m_used < MAX_SNOOZE)) begin
                    m_mode  = MD_SNOOZE;
                    m_used  = m_used + 1;
                    m_snz_s = SNOOZE_MIN * 60;
                end else if (ena) begin
                    m_ring_s = m_ring_s + 1;
                    if (m_ring_s >= RING_TIMEOUT_S) to_idle();
                end
            end else begin
                if (ena) begin
                    m_snz_s = m_snz_s - 1;
                    if (m_snz_s == 0) start_ring();
                end
            end
            if (set_alarm && ok) begin
                m_al_h = set_hh;
                m_al_m = set_mm;
                m_al_p = set_pm;
            end
        end
    endtask

    // Model advances on the same edge the DUT samples.
    always @(posedge clk) model_step();

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ringing", 16'(ringing), 16'(m_mode == MD_RING));
            chk("snoozing", 16'(snoozing), 16'(m_mode == MD_SNOOZE));
            chk("buzz", 16'(buzz), 16'(exp_buzz()));
            chk("snooze_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used));
            chk("load_err", 16'(load_err), 16'(m_err));
            chk("al_hh", 16'(al_hh), 16'(m_al_h));
            chk("al_mm", 16'(al_mm), 16'(m_al_m));
            chk("al_pm", 16'(al_pm), 16'(m_al_p));
        end
    end

    // 12-hour time-of-day step, as the external counter would do on ena.
    task automatic advance_time();
        if (ss == 8'd59) begin
            ss = 8'd0;
            if (mm == 8'd59) begin
                mm = 8'd0;
                if (hh == 8'd11) begin
                    hh = 8'd12;
                    pm = ~pm;
                end else if (hh == 8'd12) begin
                    hh = 8'd1;
                end else begin
                    hh = hh + 8'd1;
                end
            end else begin
                mm = mm + 8'd1;
            end
        end else begin
            ss = ss + 8'd1;
        end
    endtask

    // One clock cycle of stimulus, applied and released on falling edges.
    task automatic cyc(input bit e, input bit sz = 1'b0, input bit sp = 1'b0, input bit sa = 1'b0);
        ena       = e;
        snooze    = sz;
        stop      = sp;
        set_alarm = sa;
        @(negedge clk);
        if (e) advance_time();
        ena       = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
        set_alarm = 1'b0;
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        hh = h;
        mm = m;
        ss = s;
        pm = p;
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        chk_en    = 1'b0;
        reset     = 1'b0;
        arm       = 1'b1;
        ena       = 1'b0;
        set_alarm = 1'b0;
        set_hh    = 8'd0;
        set_mm    = 8'd0;
        set_pm    = 1'b0;
        snooze    = 1'b0;
        stop      = 1'b0;
        to_idle();
        m_al_h = 8'd7;
        m_al_m = 8'd0;
        m_al_p = 1'b0;
        m_err  = 1'b0;
        set_time(8'd6, 8'd59, 8'd58, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;

        // reset values
        lit("rst_al_hh", 16'(al_hh), 16'(m_al_h), 16'd7);
        lit("rst_al_mm", 16'(al_mm), 16'(m_al_m), 16'd0);
        lit("rst_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'd3);
        lit("rst_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        reset = 1'b1;

        // 07:00:00 AM fires, buzz on, then toggles per second
        secs(2);
        lit("pre_match_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        cyc(1'b1);
        lit("fire_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd1);
        lit("fire_buzz", 16'(buzz), 16'(exp_buzz()), 16'd1);
        cyc(1'b0);
        cyc(1'b1);
        lit("toggle_buzz", 16'(buzz), 16'(exp_buzz()), 16'd0);
        cyc(1'b0);

        // auto-silence on the 60th second of ringing
        secs(58);
        lit("ring59_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd1);
        cyc(1'b1);
        lit("timeout_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        lit("timeout_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'd3);

        // snooze cycles until exhausted
        set_time(8'd7, 8'd0, 8'd0, 1'b0);
        cyc(1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1);
            lit("snz_snoozing", 16'(snoozing), 16'(m_mode == MD_SNOOZE), 16'd1);
            lit("snz_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'(2 - k));
            secs(539);
            lit("snz539_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
            cyc(1'b1);
            lit("snz_rering", 16'(ringing), 16'(m_mode == MD_RING), 16'd1);
            lit("snz_rering_buzz", 16'(buzz), 16'(exp_buzz()), 16'd1);
        end
        cyc(1'b0, 1'b1);
        lit("snz_exhausted_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd1);
        lit("snz_exhausted_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'd0);

        // stop beats snooze
        cyc(1'b0, 1'b1, 1'b1);
        lit("stop_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        lit("stop_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'd3);
        lit("stop_buzz", 16'(buzz), 16'(exp_buzz()), 16'd0);

        // rejected then accepted alarm load
        set_hh = 8'd13;
        set_mm = 8'd5;
        set_pm = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        lit("bad_load_err", 16'(load_err), 16'(m_err), 16'd1);
        lit("bad_al_hh", 16'(al_hh), 16'(m_al_h), 16'd7);
        cyc(1'b0);
        lit("bad_load_err_clr", 16'(load_err), 16'(m_err), 16'd0);
        set_hh = 8'd12;
        set_mm = 8'd30;
        set_pm = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        lit("good_al_hh", 16'(al_hh), 16'(m_al_h), 16'd12);
        lit("good_al_mm", 16'(al_mm), 16'(m_al_m), 16'd30);
        lit("good_al_pm", 16'(al_pm), 16'(m_al_p), 16'd1);
        set_time(8'd12, 8'd29, 8'd59, 1'b0);
        secs(2);
        lit("am_no_fire", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        set_time(8'd12, 8'd29, 8'd59, 1'b1);
        secs(1);
        cyc(1'b1);
        lit("pm_fire", 16'(ringing), 16'(m_mode == MD_RING), 16'd1);

        // disarm while ringing
        arm = 1'b0;
        cyc(1'b0);
        lit("disarm_ringing", 16'(ringing), 16'(m_mode == MD_RING), 16'd0);
        arm = 1'b1;

        // reset during snooze
        set_time(8'd12, 8'd30, 8'd0, 1'b1);
        cyc(1'b1);
        cyc(1'b0, 1'b1);
        secs(5);
        lit("pre_rst_snoozing", 16'(snoozing), 16'(m_mode == MD_SNOOZE), 16'd1);
        reset = 1'b0;
        cyc(1'b0);
        lit("midrst_snoozing", 16'(snoozing), 16'(m_mode == MD_SNOOZE), 16'd0);
        lit("midrst_al_hh", 16'(al_hh), 16'(m_al_h), 16'd7);
        lit("midrst_left", 16'(snooze_left), 16'(MAX_SNOOZE - m_used), 16'd3);
        lit("midrst_buzz", 16'(buzz), 16'(exp_buzz()), 16'd0);
        reset = 1'b1;

        // randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 8000; i++) begin
            bit e;
            bit sz;
            bit sp;
            bit sa;
            arm   = ($urandom_range(0, 399) != 0);
            reset = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 149) == 0)
                set_time(m_al_h, m_al_m, 8'd0, m_al_p);
            sa = ($urandom_range(0, 99) == 0);
            if (sa) begin
                set_hh = 8'($urandom_range(0, 14));
                set_mm = 8'($urandom_range(0, 63));
                set_pm = 1'($urandom_range(0, 1));
            end
            e  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 39) == 0);
            sp = ($urandom_range(0, 299) == 0);
            cyc(e, sz, sp, sa);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
